rast_perf_counter: RTL

Synthesizable successor to the bench-only performance monitor. It observes the rasterizer pipeline handshakes and accumulates six saturating event counters across a start/stop window. Sample-hit counting is parametrised over MULTI_TEST parallel sample lanes. The block sits beside rast in top_rast and streams counter results out serially over a valid/ready port, so silicon and emulation runs report the same cycles/triangle figures as simulation.

---
 rtl/rast_perf_pkg.sv | 20 ++
 rtl/rast_perf_counter_if.sv | 29 ++
 rtl/rast_sat_counter.sv | 34 +++
 rtl/rast_perf_counter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/rast_perf_pkg.sv
// Shared types and constants for the rasterizer performance counter block.
package rast_perf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2,
    DUMP  = 2'd3
  } state_t;

  localparam int NUM_CNT = 6;

  localparam int CNT_CYC    = 0;
  localparam int CNT_TRI    = 1;
  localparam int CNT_STALL  = 2;
  localparam int CNT_SAMP   = 3;
  localparam int CNT_HIT    = 4;
  localparam int CNT_HITCYC = 5;

endpackage

// File: rtl/rast_perf_counter_if.sv
// Serial counter-result stream from rast_perf_counter to its consumer.
// Handshake: a word transfers on a rising clk edge where cnt_valid & cnt_ready;
// while cnt_valid is high and cnt_ready low, cnt_idx/cnt_data/cnt_ovf hold stable
// and cnt_valid never drops; cnt_ready may be driven independently of cnt_valid.
interface rast_perf_counter_if #(
  parameter int CNT_W = 32
);
  logic             cnt_valid;
  logic             cnt_ready;
  logic [2:0]       cnt_idx;
  logic [CNT_W-1:0] cnt_data;
  logic             cnt_ovf;

  modport master (
    output cnt_valid,
    output cnt_idx,
    output cnt_data,
    output cnt_ovf,
    input  cnt_ready
  );

  modport slave (
    input  cnt_valid,
    input  cnt_idx,
    input  cnt_data,
    input  cnt_ovf,
    output cnt_ready
  );
endinterface

// File: rtl/rast_sat_counter.sv
// One saturating accumulator with a sticky overflow flag.
module rast_sat_counter #(
  parameter int CNT_W = 32,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  // One extra bit catches the carry out, which is exactly the saturation case.
  logic [CNT_W:0] sum;

  assign sum = {1'b0, value} + {{(CNT_W + 1 - INC_W){1'b0}}, inc};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (en) begin
      if (sum[CNT_W]) begin
        value <= '1;
        ovf   <= 1'b1;
      end else begin
        value <= sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rast_perf_counter.sv
// Rasterizer performance monitor: six saturating event counters over a
// start/stop window, dumped serially over a valid/ready stream from HOLD.
module rast_perf_counter
  import rast_perf_pkg::*;
#(
  parameter int MULTI_TEST = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  perf_start,
  input  logic                  perf_stop,
  input  logic                  dump_req,
  input  logic                  validTri_R10H,
  input  logic                  halt_RnnnnL,
  input  logic                  validSamp_R16H,
  input  logic [MULTI_TEST-1:0] hit_valid_R18H,
  rast_perf_counter_if.master   cnt_if,
  output logic                  busy,
  output state_t                state_dbg
);

  localparam int         HIT_W    = $clog2(MULTI_TEST + 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_CNT - 1);

  state_t             state;
  logic               clr;
  logic               count_en;
  logic [NUM_CNT-1:0] ev;
  logic [HIT_W-1:0]   hit_inc;
  logic [CNT_W-1:0]   cnt_val [NUM_CNT];
  logic [NUM_CNT-1:0] cnt_ovf_v;
  logic [2:0]         idx_nxt;

  // A start in the same cycle as events wins over them: clr has priority in each counter.
  assign clr      = perf_start && (state != DUMP);
  assign count_en = (state == COUNT);
  assign idx_nxt  = cnt_if.cnt_idx + 3'd1;

  always_comb begin
    hit_inc = '0;
    for (int i = 0; i < MULTI_TEST; i++) begin
      hit_inc = hit_inc + HIT_W'(hit_valid_R18H[i]);
    end
  end

  always_comb begin
    ev             = '0;
    ev[CNT_CYC]    = 1'b1;
    ev[CNT_TRI]    = validTri_R10H & halt_RnnnnL;
    ev[CNT_STALL]  = validTri_R10H & ~halt_RnnnnL;
    ev[CNT_SAMP]   = validSamp_R16H;
    ev[CNT_HIT]    = |hit_valid_R18H;
    ev[CNT_HITCYC] = |hit_valid_R18H;
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    if (i == CNT_HIT) begin : g_multi
      rast_sat_counter #(.CNT_W(CNT_W), .INC_W(HIT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (count_en & ev[i]),
        .inc   (hit_inc),
        .value (cnt_val[i]),
        .ovf   (cnt_ovf_v[i])
      );
    end else begin : g_single
      rast_sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (count_en & ev[i]),
        .inc   (1'b1),
        .value (cnt_val[i]),
        .ovf   (cnt_ovf_v[i])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      cnt_if.cnt_valid <= 1'b0;
      cnt_if.cnt_idx   <= '0;
      cnt_if.cnt_data  <= '0;
      cnt_if.cnt_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (perf_start) state <= COUNT;
        end
        COUNT: begin
          if (perf_start)     state <= COUNT;
          else if (perf_stop) state <= HOLD;
        end
        HOLD: begin
          if (perf_start) begin
            state <= COUNT;
          end else if (dump_req) begin
            state          <= DUMP;
            cnt_if.cnt_idx <= '0;
          end
        end
        DUMP: begin
          // First DUMP cycle loads word 0; afterwards each accept loads the next.
          if (!cnt_if.cnt_valid) begin
            cnt_if.cnt_valid <= 1'b1;
            cnt_if.cnt_data  <= cnt_val[cnt_if.cnt_idx];
            cnt_if.cnt_ovf   <= cnt_ovf_v[cnt_if.cnt_idx];
          end else if (cnt_if.cnt_ready) begin
            if (cnt_if.cnt_idx == LAST_IDX) begin
              cnt_if.cnt_valid <= 1'b0;
              state            <= HOLD;
            end else begin
              cnt_if.cnt_idx  <= idx_nxt;
              cnt_if.cnt_data <= cnt_val[idx_nxt];
              cnt_if.cnt_ovf  <= cnt_ovf_v[idx_nxt];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == COUNT) || (state == DUMP);
  assign state_dbg = state;

endmodule
